sram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the board's 256K x 16 external SRAM, giving the pipeline's memory stage (port 0) and a second requester such as a loader or debug port (port 1) shared access to one chip. Each 32-bit word access is split into two 16-bit SRAM accesses, and the block holds each requester's `ready` low until its transaction completes. It sits between the memory stage and the SRAM pins, replacing the single-master SRAM controller.

---
 rtl/sram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and sequencer for a 256K x 16 asynchronous SRAM.
// Each 32-bit access is split into a low and a high 16-bit half-access.
//
// state  | meaning
// S_IDLE | waiting for a request; grant, address, data and op latched on exit
// S_LOW  | half 0 (bits [15:0]) access, ACCESS_CYCLES long
// S_HIGH | half 1 (bits [31:16]) access, ACCESS_CYCLES long
// S_DONE | completion cycle, ready pulse to the granted port
module sram_arbiter #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_rd_en,
    input  logic        m0_wr_en,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_write_data,
    output logic [31:0] m0_read_data,
    output logic        m0_ready,
    input  logic        m1_rd_en,
    input  logic        m1_wr_en,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_write_data,
    output logic [31:0] m1_read_data,
    output logic        m1_ready,
    output logic        busy,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    localparam int             CW       = $clog2(ACCESS_CYCLES);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(ACCESS_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          wr_q, wr_d;
    logic [16:0]   phys_q, phys_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [15:0]   buf_lo_q, buf_lo_d;
    logic [31:0]   rd0_q, rd0_d;
    logic [31:0]   rd1_q, rd1_d;
    logic [17:0]   addr_q, addr_d;
    logic          we_n_q, we_n_d;
    logic [15:0]   dout_q, dout_d;
    logic          busy_q, busy_d;

    logic          req0, req1, gnt_sel, dq_oe;
    logic [31:0]   sel_addr;

    assign req0 = m0_rd_en | m0_wr_en;
    assign req1 = m1_rd_en | m1_wr_en;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        wr_d     = wr_q;
        phys_d   = phys_q;
        wdata_d  = wdata_q;
        buf_lo_d = buf_lo_q;
        rd0_d    = rd0_q;
        rd1_d    = rd1_q;
        addr_d   = addr_q;
        we_n_d   = we_n_q;
        dout_d   = dout_q;
        gnt_sel  = (req0 && req1) ? ~last_q : req1;
        sel_addr = gnt_sel ? m1_address : m0_address;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d = S_LOW;
                    cnt_d   = CNT_LOAD;
                    gnt_d   = gnt_sel;
                    // The pointer only moves on a real conflict.
                    if (req0 && req1)
                        last_d = gnt_sel;
                    wr_d    = gnt_sel ? m1_wr_en : m0_wr_en;
                    wdata_d = gnt_sel ? m1_write_data : m0_write_data;
                    phys_d  = 17'((sel_addr - BASE_ADDR) >> 2);
                    addr_d  = {phys_d, 1'b0};
                    we_n_d  = ~wr_d;
                    dout_d  = wdata_d[15:0];
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    state_d = S_HIGH;
                    cnt_d   = CNT_LOAD;
                    addr_d  = {phys_q, 1'b1};
                    we_n_d  = ~wr_q;
                    dout_d  = wdata_q[31:16];
                    if (!wr_q)
                        buf_lo_d = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    // Strobe released one cycle early so the address never moves under a low WE.
                    if (cnt_q == CNT_ONE)
                        we_n_d = 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    we_n_d  = 1'b1;
                    if (!wr_q) begin
                        if (gnt_q)
                            rd1_d = {SRAM_DQ, buf_lo_q};
                        else
                            rd0_d = {SRAM_DQ, buf_lo_q};
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE)
                        we_n_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            phys_q   <= '0;
            wdata_q  <= '0;
            buf_lo_q <= '0;
            rd0_q    <= '0;
            rd1_q    <= '0;
            addr_q   <= '0;
            we_n_q   <= 1'b1;
            dout_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            phys_q   <= phys_d;
            wdata_q  <= wdata_d;
            buf_lo_q <= buf_lo_d;
            rd0_q    <= rd0_d;
            rd1_q    <= rd1_d;
            addr_q   <= addr_d;
            we_n_q   <= we_n_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
        end
    end

    assign dq_oe   = wr_q && ((state_q == S_LOW) || (state_q == S_HIGH));
    assign SRAM_DQ = dq_oe ? dout_q : 16'bz;

    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign m0_read_data = rd0_q;
    assign m1_read_data = rd1_q;
    assign busy         = busy_q;

    assign m0_ready = ~req0 | ((state_q == S_DONE) && !gnt_q);
    assign m1_ready = ~req1 | ((state_q == S_DONE) &&  gnt_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM model, vector table and completion scoreboard.
module tb_sram_arbiter;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_rd_en = 1'b0, m0_wr_en = 1'b0, m1_rd_en = 1'b0, m1_wr_en = 1'b0;
    logic [31:0] m0_address = '0, m0_write_data = '0, m1_address = '0, m1_write_data = '0;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_ready, m1_ready, busy;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n, sram_we_n;

    logic [15:0] mem [0:262143];
    logic        model_oe = 1'b0;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_address(m0_address),
        .m0_write_data(m0_write_data), .m0_read_data(m0_read_data), .m0_ready(m0_ready),
        .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_address(m1_address),
        .m1_write_data(m1_write_data), .m1_read_data(m1_read_data), .m1_ready(m1_ready),
        .busy(busy), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n), .SRAM_CE_N(sram_ce_n),
        .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_dq = model_oe ? mem[sram_addr] : 16'bz;
    always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    typedef struct {
        bit          port;
        int          lat;
        bit          chk_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[12];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_model[2];
    int          start_cyc[2];
    int          we_lo = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rdata_of(input bit p);
        return p ? m1_read_data : m0_read_data;
    endfunction

    function automatic bit ready_of(input bit p);
        return p ? m1_ready : m0_ready;
    endfunction

    function automatic bit req_of(input bit p);
        return p ? (m1_rd_en | m1_wr_en) : (m0_rd_en | m0_wr_en);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] phys;
        logic [17:0] ha;
        phys = addr - BASE;
        ha   = {phys[18:2], 1'b0};
        return {mem[{ha[17:1], 1'b1}], mem[ha]};
    endfunction

    task automatic drive(input bit p, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            m1_rd_en = rd; m1_wr_en = wr; m1_address = a; m1_write_data = d;
        end else begin
            m0_rd_en = rd; m0_wr_en = wr; m0_address = a; m0_write_data = d;
        end
        start_cyc[p] = cyc;
        if (rd && !wr) model_oe = 1'b1;
    endtask

    task automatic release_port(input bit p);
        if (p) begin m1_rd_en = 1'b0; m1_wr_en = 1'b0; end
        else   begin m0_rd_en = 1'b0; m0_wr_en = 1'b0; end
    endtask

    task automatic run_sb(input int budget);
        int   n = 0;
        exp_t e;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (!sram_we_n) we_lo++;
            for (int p = 0; p < 2; p++) begin
                if (req_of(p[0]) && ready_of(p[0])) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ready_port", 32'(p), 32'hFF);
                    end else begin
                        e = sb.pop_front();
                        chk("grant_order", 32'(p), 32'(e.port));
                        chk("ready_latency", 32'(cyc - start_cyc[p]), 32'(e.lat));
                        if (e.chk_rd) begin
                            chk("read_data", rdata_of(p[0]), e.rdata);
                            rd_model[p] = e.rdata;
                        end else begin
                            chk("read_data_kept", rdata_of(p[0]), rd_model[p]);
                        end
                    end
                    release_port(p[0]);
                end
            end
        end
        if (sb.size() > 0) begin
            chk("ready_timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
            release_port(1'b0);
            release_port(1'b1);
        end
        model_oe = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd_model[0] = '0;
        rd_model[1] = '0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'd1028,   32'hDEADBEEF, 32'h0,        5, 2};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'd1028,   32'h0,        32'hDEADBEEF, 5, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'd2048,   32'hCAFEF00D, 32'h0,        5, 2};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'd2048,   32'h0,        32'hCAFEF00D, 5, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'd2048,   32'h0,        32'hCAFEF00D, 5, 0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'd1028,   32'h12345678, 32'h0,        5, 2};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'd1028,   32'h0,        32'h12345678, 5, 0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'd525308, 32'hA5A55A5A, 32'h0,        5, 2};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'd525308, 32'h0,        32'hA5A55A5A, 5, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'd1020,   32'h0BADF00D, 32'h0,        5, 2};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'd525308, 32'h0,        32'h0BADF00D, 5, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'd1020,   32'h0,        32'h0BADF00D, 5, 0};

        rd_model[0] = '0;
        rd_model[1] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_we_n", 32'(sram_we_n), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sram_addr", 32'(sram_addr), 32'd0);
        chk("reset_m0_read_data", m0_read_data, 32'd0);
        chk("reset_m1_read_data", m1_read_data, 32'd0);
        chk("reset_m0_ready", 32'(m0_ready), 32'd1);
        chk("reset_m1_ready", 32'(m1_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Single-port transactions
        foreach (vecs[i]) begin
            we_lo = 0;
            drive(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            sb.push_back('{vecs[i].port, vecs[i].exp_lat, vecs[i].rd && !vecs[i].wr, vecs[i].exp_rd});
            run_sb(40);
            chk("we_low_cycles", 32'(we_lo), 32'(vecs[i].exp_we));
            if (vecs[i].wr)
                chk("sram_word", mem_word(vecs[i].addr), vecs[i].wdata);
            @(negedge clk);
            chk("read_data_hold", rdata_of(vecs[i].port), rd_model[vecs[i].port]);
        end

        // Contention straight after reset: port 0 first, then port 1
        apply_reset();
        drive(1'b0, 1'b0, 1'b1, 32'd3000, 32'h11112222);
        drive(1'b1, 1'b0, 1'b1, 32'd3004, 32'h33334444);
        sb.push_back('{1'b0, 5, 1'b0, 32'h0});
        sb.push_back('{1'b1, 11, 1'b0, 32'h0});
        run_sb(60);
        chk("contention_word_p0", mem_word(32'd3000), 32'h11112222);
        chk("contention_word_p1", mem_word(32'd3004), 32'h33334444);

        // Repeated contention: pointer now favours port 1
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'd3004, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'd3000, 32'h0);
        sb.push_back('{1'b1, 5, 1'b1, 32'h11112222});
        sb.push_back('{1'b0, 11, 1'b1, 32'h33334444});
        run_sb(60);
        @(negedge clk);

        // Withdrawn request during HIGH
        drive(1'b0, 1'b0, 1'b1, 32'd4000, 32'h55556666);
        repeat (3) @(negedge clk);
        chk("withdraw_busy_high", 32'(busy), 32'd1);
        release_port(1'b0);
        repeat (2) @(negedge clk);
        chk("withdraw_done_ready", 32'(m0_ready), 32'd1);
        chk("withdraw_done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("withdraw_idle_busy", 32'(busy), 32'd0);
        chk("withdraw_word", mem_word(32'd4000), 32'h55556666);

        // Reset in the middle of a write
        drive(1'b0, 1'b0, 1'b1, 32'd5000, 32'h77778888);
        @(negedge clk);
        chk("midreset_pre_we_n", 32'(sram_we_n), 32'd0);
        chk("midreset_pre_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("midreset_we_n", 32'(sram_we_n), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        release_port(1'b0);
        @(negedge clk);
        rst = 1'b1;
        rd_model[0] = '0;
        rd_model[1] = '0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0);
        sb.push_back('{1'b0, 5, 1'b1, 32'h12345678});
        run_sb(40);
        @(negedge clk);
        chk("post_reset_read_hold", m0_read_data, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
